// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    // Bit-counter width; kept at least 1 so the counter is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor: x - y - bin.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin LSB first with one shared
// full-subtractor cell, one bit per cycle.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] sd_next;

    sub_bit_cell u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign sd_next = {cell_diff, sd[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    sd     <= sd_next;
                    borrow <= cell_bout;
                    if (cnt == LAST) begin
                        // Last bit: publish the completed result with the final borrow.
                        diff  <= sd_next;
                        bout  <= cell_bout;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    int tests = 0;
    int fails = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation from an IDLE cycle; diff must hold hold_diff until done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input logic [7:0] ediff, input logic ebout,
                          input logic [7:0] hold_diff, input string tag);
        int n;
        int gaps;
        int holds;
        a = ta;
        b = tb;
        bin = tbin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ta;
        b = ~tb;
        bin = ~tbin;
        n = 1;
        gaps = 0;
        holds = 0;
        while (!done && n < 20) begin
            if (!busy) gaps++;
            if (diff !== hold_diff) holds++;
            tick();
            n++;
        end
        if (!busy) gaps++;
        chk({tag, " latency"}, n, 9);
        chk({tag, " diff"}, diff, ediff);
        chk({tag, " bout"}, bout, ebout);
        chk({tag, " busy gaps"}, gaps, 0);
        chk({tag, " diff held"}, holds, 0);
        tick();
        chk({tag, " idle after"}, {done, busy}, 2'b00);
    endtask

    initial begin
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] ibits;
        int dcount;
        int gaps;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8'h00, "op05_03");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8'h02, "op00_01");
        run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 8'hFF, "op10_10_b");
        run_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, "opFF_00");
        tick();
        tick();
        chk("hold between ops", diff, 8'hFF);
        run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 8'hFF, "op80_7F_b");

        // Starts during RUN cycle 3 and the DONE cycle must be ignored.
        a = 8'h09;
        b = 8'h04;
        bin = 1'b0;
        start = 1'b1;
        tick();
        dcount = 0;
        gaps = 0;
        for (int n = 1; n <= 9; n++) begin
            if (n < 9 && done) dcount++;
            if (!busy) gaps++;
            if (n == 9) begin
                chk("ignore done", done, 1);
                chk("ignore diff", diff, 8'h05);
                chk("ignore bout", bout, 0);
            end
            if (n == 3 || n == 9) begin
                start = 1'b1;
                a = 8'h00;
                b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("ignore early done", dcount, 0);
        chk("ignore busy gaps", gaps, 0);
        chk("ignore idle", {done, busy}, 2'b00);
        tick();
        chk("ignore not queued", busy, 0);

        // Reset during RUN cycle 4 abandons the operation.
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst diff", diff, 0);
        chk("midrst bout", bout, 0);
        chk("midrst done", done, 0);
        dcount = 0;
        for (int n = 0; n < 12; n++) begin
            if (done || busy) dcount++;
            tick();
        end
        chk("midrst quiet", dcount, 0);
        run_op(8'h03, 8'h07, 1'b0, 8'hFC, 1'b1, 8'h00, "op03_07");

        // Reset wins over start in the same cycle.
        a = 8'h44;
        b = 8'h22;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rst+start busy", busy, 0);
        tick();
        chk("rst+start stays idle", busy, 0);

        // Start held high: accepted at cycles 0, 10, 20 with done at 9, 19, 29.
        for (int i = 0; i < 30; i++) begin
            ibits = 8'(i);
            va = 8'(i * 17 + 3);
            vb = 8'(i * 5 + 1);
            a = va;
            b = vb;
            bin = ibits[1];
            start = 1'b1;
            chk($sformatf("b2b done c%0d", i), done, (i == 9 || i == 19 || i == 29));
            if (i == 9) begin
                chk("b2b diff0", diff, 8'h02);
                chk("b2b bout0", bout, 0);
            end
            if (i == 19) begin
                chk("b2b diff1", diff, 8'h79);
                chk("b2b bout1", bout, 0);
            end
            if (i == 29) begin
                chk("b2b diff2", diff, 8'hF2);
                chk("b2b bout2", bout, 1);
            end
            tick();
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
